// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller.
// MC_BNE_EN adds the bne opcode and its BNEEX state (code 12).
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
`ifdef MC_BNE_EN
    ,
    S_BNEEX   = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
`ifdef MC_BNE_EN
      OP_BNE: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// State-to-control-word decoder; strobes gated by mem_ready, zero and reset.
// MC_BNE_EN adds the BNEEX decode.
module mc_ctrl_outdec
  import mips_mc_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  input  logic   zero_i,
  input  logic   illegal_i,
  input  logic   rst_n_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.pcsrc   = PCSRC_ALU;
        ctrl_o.irwrite = mem_ready_i;
        ctrl_o.pcen    = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alusrcb    = SRCB_IMMSH;
        ctrl_o.illegal_op = illegal_i;
        ctrl_o.instr_done = illegal_i;
      end
      S_MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.memtoreg   = 1'b1;
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_req    = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.memwrite   = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_RTYPEEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_B;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl_o.regdst     = 1'b1;
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BEQEX: begin
        ctrl_o.alusrca    = 1'b1;
        ctrl_o.aluop      = ALUOP_SUB;
        ctrl_o.pcsrc      = PCSRC_ALUOUT;
        ctrl_o.pcen       = zero_i;
        ctrl_o.instr_done = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        ctrl_o.alusrca    = 1'b1;
        ctrl_o.aluop      = ALUOP_SUB;
        ctrl_o.pcsrc      = PCSRC_ALUOUT;
        ctrl_o.pcen       = ~zero_i;
        ctrl_o.instr_done = 1'b1;
      end
`endif
      S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_JEX: begin
        ctrl_o.pcsrc      = PCSRC_JUMP;
        ctrl_o.pcen       = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
    // Reset holds state at FETCH; kill every strobe so nothing is written.
    if (!rst_n_i) begin
      ctrl_o.mem_req    = 1'b0;
      ctrl_o.memwrite   = 1'b0;
      ctrl_o.irwrite    = 1'b0;
      ctrl_o.pcen       = 1'b0;
      ctrl_o.regwrite   = 1'b0;
      ctrl_o.instr_done = 1'b0;
      ctrl_o.illegal_op = 1'b0;
    end
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main controller: state register and next-state logic.
// Define MC_BNE_EN to support bne (opcode 000101) via state BNEEX.
module mips_mc_ctrl
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .zero_i      (zero),
    .illegal_i   (~op_legal(op)),
    .rst_n_i     (rst_n),
    .ctrl_o      (ctrl)
  );

  assign mem_req    = ctrl.mem_req;
  assign memwrite   = ctrl.memwrite;
  assign iord       = ctrl.iord;
  assign irwrite    = ctrl.irwrite;
  assign pcen       = ctrl.pcen;
  assign pcsrc      = ctrl.pcsrc;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign aluop      = ctrl.aluop;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign regwrite   = ctrl.regwrite;
  assign instr_done = ctrl.instr_done;
  assign illegal_op = ctrl.illegal_op;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-cycle expected control words plus literal instruction lengths.
module tb_mips_mc_ctrl;

  localparam int W = 21;
`ifdef MC_BNE_EN
  localparam int BNE_LEN = 3;
`else
  localparam int BNE_LEN = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, iord, irwrite, pcen;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic       alusrca, regdst, memtoreg, regwrite, instr_done, illegal_op;
  logic [3:0] state;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;
  int cyc;
  int exp_len;

  mips_mc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .memwrite   (memwrite),
    .iord       (iord),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state      (state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic legal(input logic [5:0] o);
    case (o)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
`ifdef MC_BNE_EN
      6'b000101: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Control word the spec tables require for one cycle in state st.
  function automatic logic [W-1:0] exp_word(input int st, input logic rdy, input logic z,
                                            input logic [5:0] opc, input logic run);
    logic [3:0] s4;
    logic mr, mw, io, irw, pe, asa, rd, mtr, rw, dn, il;
    logic [1:0] ps, asb, ao;
    s4 = st[3:0];
    {mr, mw, io, irw, pe, asa, rd, mtr, rw, dn, il} = '0;
    ps = 2'd0; asb = 2'd0; ao = 2'd0;
    case (st)
      0:  begin mr = 1; asb = 2'd1; irw = rdy; pe = rdy; end
      1:  begin asb = 2'd3; il = !legal(opc); dn = il; end
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin mr = 1; io = 1; end
      4:  begin mtr = 1; rw = 1; dn = 1; end
      5:  begin mr = 1; io = 1; mw = 1; dn = rdy; end
      6:  begin asa = 1; ao = 2'd2; end
      7:  begin rd = 1; rw = 1; dn = 1; end
      8:  begin asa = 1; ao = 2'd1; ps = 2'd1; pe = z; dn = 1; end
      9:  begin asa = 1; asb = 2'd2; end
      10: begin rw = 1; dn = 1; end
      11: begin ps = 2'd2; pe = 1; dn = 1; end
      12: begin asa = 1; ao = 2'd1; ps = 2'd1; pe = !z; dn = 1; end
      default: ;
    endcase
    if (!run) {mr, mw, irw, pe, rw, dn, il} = '0;
    return {s4, mr, mw, io, irw, pe, ps, asa, asb, ao, rd, mtr, rw, dn, il};
  endfunction

  // driver tasks
  task automatic push_cycle(input int st, input logic rdy, input logic z, input logic [5:0] opc);
    mem_ready = rdy;
    zero      = z;
    op        = opc;
    exp_q.push_back(exp_word(st, rdy, z, opc, rst_n));
    @(posedge clk);
    #1;
  endtask

  task automatic do_instr(input logic [5:0] opc, input logic z, input int fst, input int mst,
                          input int len);
    exp_len = len;
    for (int i = 0; i < fst; i++) push_cycle(0, 1'b0, z, opc);
    push_cycle(0, 1'b1, z, opc);
    push_cycle(1, 1'b0, z, opc);
    case (opc)
      6'b100011: begin
        push_cycle(2, 1'b0, z, opc);
        for (int i = 0; i < mst; i++) push_cycle(3, 1'b0, z, opc);
        push_cycle(3, 1'b1, z, opc);
        push_cycle(4, 1'b0, z, opc);
      end
      6'b101011: begin
        push_cycle(2, 1'b1, z, opc);
        for (int i = 0; i < mst; i++) push_cycle(5, 1'b0, z, opc);
        push_cycle(5, 1'b1, z, opc);
      end
      6'b000000: begin push_cycle(6, 1'b1, z, opc); push_cycle(7, 1'b0, z, opc); end
      6'b000100: push_cycle(8, 1'b1, z, opc);
      6'b001000: begin push_cycle(9, 1'b0, z, opc); push_cycle(10, 1'b1, z, opc); end
      6'b000010: push_cycle(11, 1'b0, z, opc);
`ifdef MC_BNE_EN
      6'b000101: push_cycle(12, 1'b0, z, opc);
`endif
      default: ;
    endcase
  endtask

  // scoreboard: compare every cycle, and pin instruction lengths on instr_done
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb, aluop,
           regdst, memtoreg, regwrite, instr_done, illegal_op};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ctrl_word t=%0t state=%0d act=%06h exp=%06h", $time, state, a, e);
      end
    end
    if (!rst_n) cyc = 0;
    else begin
      cyc++;
      if (instr_done === 1'b1) begin
        if (exp_len != 0) begin
          checks++;
          if (cyc != exp_len) begin
            errors++;
            $display("FAIL instr_len t=%0t act=%0d exp=%0d", $time, cyc, exp_len);
          end
        end
        cyc = 0;
      end
    end
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; exp_len = 0;
    rst_n = 1'b0; op = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    push_cycle(0, 1'b1, 1'b0, 6'd0);
    push_cycle(0, 1'b0, 1'b1, 6'b100011);
    rst_n = 1'b1;

    do_instr(6'b100011, 1'b0, 0, 0, 5);  // lw
    do_instr(6'b101011, 1'b0, 0, 2, 6);  // sw, 2 stall cycles in MEMWR
    do_instr(6'b000100, 1'b1, 0, 0, 3);  // beq taken
    do_instr(6'b000100, 1'b0, 0, 0, 3);  // beq not taken
    do_instr(6'b000000, 1'b1, 3, 0, 7);  // R-type behind a 3-cycle fetch stall
    do_instr(6'b001000, 1'b0, 0, 0, 4);  // addi
    do_instr(6'b000010, 1'b1, 0, 0, 3);  // j
    do_instr(6'b111111, 1'b0, 0, 0, 2);  // illegal
    do_instr(6'b000101, 1'b0, 0, 0, BNE_LEN);
    do_instr(6'b000101, 1'b1, 0, 0, BNE_LEN);
    do_instr(6'b100011, 1'b1, 1, 1, 7);  // lw with fetch and read stalls

    // lw aborted by reset while in MEMWB
    exp_len = 0;
    push_cycle(0, 1'b1, 1'b0, 6'b100011);
    push_cycle(1, 1'b1, 1'b0, 6'b100011);
    push_cycle(2, 1'b1, 1'b0, 6'b100011);
    push_cycle(3, 1'b1, 1'b0, 6'b100011);
    rst_n = 1'b0;
    push_cycle(0, 1'b1, 1'b0, 6'b100011);
    push_cycle(0, 1'b1, 1'b0, 6'b100011);
    rst_n = 1'b1;
    do_instr(6'b001000, 1'b0, 0, 0, 4);  // FETCH issued in the release cycle
    do_instr(6'b101011, 1'b0, 0, 0, 4);  // sw, no stall

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
